// File: rtl/br_resolve_unit.sv
// Resolves EX-stage branches/jumps against the fetch prediction and drives redirect, flush and BPU update.
// Latency: one cycle; every output is registered and appears the cycle after the resolving EX cycle.
// Backpressure: stall_in freezes all state; pulses are cleared rather than repeated while stalled.
module br_resolve_unit #(
    parameter int PC_SIZE      = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  ex_valid,
    input  logic                  stall_in,
    input  logic                  is_conditional_branch,
    input  logic                  is_jal,
    input  logic                  is_jalr,
    input  logic                  predict_taken,
    input  logic [PC_SIZE-1:0]    predict_pc,
    input  logic [PC_SIZE-1:0]    pc,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [PC_SIZE-1:0]    imm,
    input  logic                  cnt_clear,
    output logic                  br_taken,
    output logic [PC_SIZE-1:0]    br_target,
    output logic                  misprediction,
    output logic                  illegal_branch,
    output logic                  bpu_update_valid,
    output logic [PC_SIZE-1:0]    bpu_update_pc,
    output logic                  bpu_update_taken,
    output logic [PC_SIZE-1:0]    bpu_update_target,
    output logic                  flush_active,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;

    logic               sel_jalr;
    logic               sel_jal;
    logic               sel_br;
    logic               resolve;
    logic               cond_taken;
    logic               illegal;
    logic               actual_taken;
    logic               mispredict;
    logic [PC_SIZE-1:0] rs1_pc;
    logic [PC_SIZE-1:0] target;
    logic [PC_SIZE-1:0] redirect;
    logic               eq;
    logic               lt_s;
    logic               lt_u;

    // JALR overrides JAL, which overrides a conditional branch, when decode flags overlap.
    assign sel_jalr = is_jalr;
    assign sel_jal  = is_jal & ~is_jalr;
    assign sel_br   = is_conditional_branch & ~is_jal & ~is_jalr;

    assign flush_active = (state_q == FLUSH);
    assign resolve      = ex_valid & ~stall_in & ~flush_active
                        & (is_conditional_branch | is_jal | is_jalr);

    assign eq     = (rs1_data == rs2_data);
    assign lt_s   = ($signed(rs1_data) < $signed(rs2_data));
    assign lt_u   = (rs1_data < rs2_data);
    assign rs1_pc = PC_SIZE'(rs1_data);

    // Branch condition decode; 010/011 are reserved and resolve not-taken.
    always_comb begin
        cond_taken = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            3'b000:  cond_taken = eq;
            3'b001:  cond_taken = ~eq;
            3'b100:  cond_taken = lt_s;
            3'b101:  cond_taken = ~lt_s;
            3'b110:  cond_taken = lt_u;
            3'b111:  cond_taken = ~lt_u;
            default: illegal    = sel_br;
        endcase
    end

    // Actual direction, target, misprediction and the address fetch must restart from.
    always_comb begin
        actual_taken = (sel_jalr | sel_jal) ? 1'b1 : (sel_br & cond_taken);
        if (sel_jalr) begin
            target = (rs1_pc + imm) & {{(PC_SIZE-1){1'b1}}, 1'b0};
        end else begin
            target = pc + imm;
        end
        mispredict = (actual_taken != predict_taken)
                   | (actual_taken & predict_taken & (predict_pc != target));
        redirect   = actual_taken ? target : (pc + PC_SIZE'(4));
    end

    // Output pulses re-evaluate every cycle so a stall clears them instead of repeating them.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            br_taken          <= 1'b0;
            br_target         <= '0;
            misprediction     <= 1'b0;
            illegal_branch    <= 1'b0;
            bpu_update_valid  <= 1'b0;
            bpu_update_pc     <= '0;
            bpu_update_taken  <= 1'b0;
            bpu_update_target <= '0;
        end else begin
            br_taken          <= resolve & actual_taken & mispredict;
            misprediction     <= resolve & mispredict;
            illegal_branch    <= resolve & illegal;
            bpu_update_valid  <= resolve;
            bpu_update_pc     <= resolve ? pc : '0;
            bpu_update_taken  <= resolve & actual_taken;
            bpu_update_target <= resolve ? target : '0;
            if (resolve && mispredict) begin
                br_target <= redirect;
            end
        end
    end

    // Squash-window state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Open the window on a resolved mispredict; close it after FLUSH_CYCLES unstalled cycles.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (resolve && mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (!stall_in) begin
                    if (fcnt_q <= 4'd1) begin
                        state_d = IDLE;
                        fcnt_d  = 4'd0;
                    end else begin
                        fcnt_d = fcnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 4'd0;
            end
        endcase
    end

    // Saturating performance counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (cnt_clear) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (resolve) begin
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_WIDTH'(1);
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit with a small reference model and an expected-result queue.
// Latency: each step drives one EX cycle and checks the registered outputs one cycle later.
// Backpressure: stall cycles are driven explicitly and the model freezes the squash window with them.
module tb_br_resolve_unit;

    localparam int PW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int FC = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          ex_valid = 1'b0;
    logic          stall_in = 1'b0;
    logic          is_conditional_branch = 1'b0;
    logic          is_jal = 1'b0;
    logic          is_jalr = 1'b0;
    logic          predict_taken = 1'b0;
    logic [PW-1:0] predict_pc = '0;
    logic [PW-1:0] pc = '0;
    logic [2:0]    funct3 = '0;
    logic [DW-1:0] rs1_data = '0;
    logic [DW-1:0] rs2_data = '0;
    logic [PW-1:0] imm = '0;
    logic          cnt_clear = 1'b0;

    logic          br_taken;
    logic [PW-1:0] br_target;
    logic          misprediction;
    logic          illegal_branch;
    logic          bpu_update_valid;
    logic [PW-1:0] bpu_update_pc;
    logic          bpu_update_taken;
    logic [PW-1:0] bpu_update_target;
    logic          flush_active;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    always #5 clk = ~clk;

    br_resolve_unit #(
        .PC_SIZE(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .arst_n(arst_n), .ex_valid(ex_valid), .stall_in(stall_in),
        .is_conditional_branch(is_conditional_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .predict_taken(predict_taken), .predict_pc(predict_pc), .pc(pc), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .cnt_clear(cnt_clear),
        .br_taken(br_taken), .br_target(br_target), .misprediction(misprediction),
        .illegal_branch(illegal_branch), .bpu_update_valid(bpu_update_valid),
        .bpu_update_pc(bpu_update_pc), .bpu_update_taken(bpu_update_taken),
        .bpu_update_target(bpu_update_target), .flush_active(flush_active),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] upc;
        logic        utk;
        logic [31:0] utgt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        m_flush = 1'b0;
    int          m_fcnt  = 0;
    int          m_bc    = 0;
    int          m_mc    = 0;
    logic [31:0] m_tgt   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".br_taken"},   32'(br_taken), 32'h0);
        chk({tag, ".br_target"},  br_target, 32'h0);
        chk({tag, ".mispred"},    32'(misprediction), 32'h0);
        chk({tag, ".illegal"},    32'(illegal_branch), 32'h0);
        chk({tag, ".upd_valid"},  32'(bpu_update_valid), 32'h0);
        chk({tag, ".upd_pc"},     bpu_update_pc, 32'h0);
        chk({tag, ".upd_taken"},  32'(bpu_update_taken), 32'h0);
        chk({tag, ".upd_target"}, bpu_update_target, 32'h0);
        chk({tag, ".flush"},      32'(flush_active), 32'h0);
        chk({tag, ".bcount"},     32'(branch_count), 32'h0);
        chk({tag, ".mcount"},     32'(mispredict_count), 32'h0);
    endtask

    // One EX cycle: drive, predict the outcome, clock, compare.
    task automatic step(input string tag, input logic v, input logic st, input logic c,
                        input logic j, input logic jr, input logic pt, input logic [31:0] ppc,
                        input logic [31:0] p, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic clr);
        exp_t        e;
        logic        res, tk, mis, ill, pushed;
        logic [31:0] tgt;
        ex_valid = v; stall_in = st; is_conditional_branch = c; is_jal = j; is_jalr = jr;
        predict_taken = pt; predict_pc = ppc; pc = p; funct3 = f3;
        rs1_data = a; rs2_data = b; imm = im; cnt_clear = clr;
        res = v & ~st & ~m_flush & (c | j | jr);
        tk = 1'b0; mis = 1'b0; ill = 1'b0; tgt = '0; pushed = 1'b0;
        if (res) begin
            if (jr) begin
                tk = 1'b1; tgt = (a + im) & 32'hFFFF_FFFE;
            end else if (j) begin
                tk = 1'b1; tgt = p + im;
            end else begin
                tgt = p + im;
                case (f3)
                    3'd0:    tk = (a == b);
                    3'd1:    tk = (a != b);
                    3'd4:    tk = ($signed(a) < $signed(b));
                    3'd5:    tk = ($signed(a) >= $signed(b));
                    3'd6:    tk = (a < b);
                    3'd7:    tk = (a >= b);
                    default: begin tk = 1'b0; ill = 1'b1; end
                endcase
            end
            mis = (tk != pt) | (tk & pt & (ppc != tgt));
            e.taken = tk & mis; e.mis = mis; e.ill = ill;
            e.upc = p; e.utk = tk; e.utgt = tgt;
            if (mis) m_tgt = tk ? tgt : p + 32'd4;
            sb_q.push_back(e);
            pushed = 1'b1;
        end
        if (m_flush && !st) begin
            if (m_fcnt == 1) m_flush = 1'b0;
            else m_fcnt--;
        end
        if (res && mis) begin
            m_flush = 1'b1; m_fcnt = FC;
        end
        if (clr) begin
            m_bc = 0; m_mc = 0;
        end else if (res) begin
            if (m_bc < CMAX) m_bc++;
            if (mis && m_mc < CMAX) m_mc++;
        end
        @(posedge clk); #1;
        if (pushed) begin
            e = sb_q.pop_front();
        end else begin
            e.taken = 1'b0; e.mis = 1'b0; e.ill = 1'b0; e.upc = '0; e.utk = 1'b0; e.utgt = '0;
        end
        chk({tag, ".br_taken"},   32'(br_taken), 32'(e.taken));
        chk({tag, ".mispred"},    32'(misprediction), 32'(e.mis));
        chk({tag, ".illegal"},    32'(illegal_branch), 32'(e.ill));
        chk({tag, ".upd_valid"},  32'(bpu_update_valid), 32'(pushed));
        chk({tag, ".upd_pc"},     bpu_update_pc, e.upc);
        chk({tag, ".upd_taken"},  32'(bpu_update_taken), 32'(e.utk));
        chk({tag, ".upd_target"}, bpu_update_target, e.utgt);
        chk({tag, ".br_target"},  br_target, m_tgt);
        chk({tag, ".flush"},      32'(flush_active), 32'(m_flush));
        chk({tag, ".bcount"},     32'(branch_count), 32'(m_bc));
        chk({tag, ".mcount"},     32'(mispredict_count), 32'(m_mc));
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic br(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                      input logic pt, input logic [31:0] ppc);
        step(tag, 1, 0, 1, 0, 0, pt, ppc, p, f3, a, b, im, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        arst_n = 1'b1;

        // BEQ taken, predicted not-taken: redirect to 0x120, two squash cycles.
        br("beq_mis", 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0, 0);
        idle("beq_fl1");
        idle("beq_fl2");
        idle("beq_done");

        // Signed vs unsigned compare of the same operands.
        br("blt_ok", 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1, 32'h240);
        br("bltu_mis", 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1, 32'h340);
        idle("bltu_fl1");
        idle("bltu_fl2");
        br("bge_s", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h10, 0, 0);
        br("bgeu", 3'd7, 32'hFFFF_FFFF, 32'd1, 32'h404, 32'h10, 1, 32'h414);
        br("bne", 3'd1, 32'd3, 32'd4, 32'h408, 32'h8, 1, 32'h410);

        // JALR clears bit 0; then branches in the squash window are ignored.
        step("jalr_mis", 1, 0, 0, 0, 1, 1, 32'h200, 32'h500, 3'd0, 32'h203, 0, 32'h0, 0);
        br("sq1", 3'd1, 32'd1, 32'd2, 32'h600, 32'h8, 0, 0);
        br("sq2", 3'd1, 32'd1, 32'd2, 32'h604, 32'h8, 0, 0);
        br("after_sq", 3'd1, 32'd1, 32'd2, 32'h608, 32'h8, 1, 32'h610);

        // JAL mispredict then a 3-cycle stall inside the squash window.
        step("jal_mis", 1, 0, 0, 1, 0, 0, 0, 32'h700, 3'd0, 0, 0, 32'h40, 0);
        step("stall1", 1, 1, 1, 0, 0, 0, 0, 32'h704, 3'd0, 1, 1, 4, 0);
        step("stall2", 1, 1, 1, 0, 0, 0, 0, 32'h704, 3'd0, 1, 1, 4, 0);
        step("stall3", 1, 1, 1, 0, 0, 0, 0, 32'h704, 3'd0, 1, 1, 4, 0);
        idle("st_fl1");
        idle("st_fl2");
        idle("st_done");

        // Reserved condition codes resolve not-taken and flag illegal.
        br("ill_010", 3'd2, 32'd1, 32'd1, 32'h800, 32'h20, 0, 0);
        br("ill_011", 3'd3, 32'd1, 32'd1, 32'h810, 32'h20, 1, 32'h830);
        idle("ill_fl1");
        idle("ill_fl2");

        // All flags set: JALR wins. Then JAL target wraps past 2^32.
        step("prio", 1, 0, 1, 1, 1, 1, 32'h1000, 32'h900, 3'd0, 32'h1000, 32'h5, 32'h0, 0);
        step("wrap", 1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 3'd0, 0, 0, 32'h20, 0);
        idle("wrap_fl1");
        idle("wrap_fl2");

        // Saturate both counters.
        for (int i = 0; i < 20; i++) br("bsat", 3'd0, 32'd1, 32'd2, 32'hA00, 32'h8, 0, 0);
        for (int i = 0; i < 16; i++) begin
            br("msat", 3'd0, 32'd7, 32'd7, 32'hB00, 32'h8, 0, 0);
            idle("msat_fl1");
            idle("msat_fl2");
        end

        // Clear coincident with a mispredicting resolve: clear wins.
        step("clr", 1, 0, 1, 0, 0, 0, 0, 32'hC00, 3'd0, 32'd1, 32'd1, 32'h10, 1);
        idle("clr_fl1");
        idle("clr_fl2");
        br("post_clr", 3'd0, 32'd1, 32'd2, 32'hC10, 32'h8, 0, 0);

        // Reset in the middle of a squash window drops the pending pulse.
        br("rst_mis", 3'd0, 32'd9, 32'd9, 32'hD00, 32'h20, 0, 0);
        arst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        m_flush = 1'b0; m_fcnt = 0; m_bc = 0; m_mc = 0; m_tgt = '0;
        @(negedge clk);
        arst_n = 1'b1;
        br("after_rst", 3'd1, 32'd1, 32'd2, 32'hE00, 32'h10, 0, 0);
        idle("after_rst_fl1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
